spi_rx: RTL and testbench

// - SPI slave receiver; the downstream consumer of spi_gen's clk_out/sel_out/data_out.
// - Synchronises SCK/CS/MOSI into the system clock and deserialises MSB-first frames.
// - Presents each received word on a valid/ready stream to the next stage.
// - SPI mode: SCK idles high, MOSI changes on SCK fall, sampled on SCK rise, CS active-low.

---
 rtl/spi_rx.sv | 174 +++++++++++++++++
 tb/tb_spi_rx.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rx.sv
// spi_rx: SPI slave receiver (SCK idles high, sampled on rise, CS_n active low, MSB first).
// Optional macro SPI_RX_FIFO_EN: buffer completed words in a show-ahead FIFO instead of one output register.
module spi_rx #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  spi_clk_in,
  input  logic                  spi_sel_in,
  input  logic                  spi_data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  busy_out,
  output logic                  frame_err_out,
  output logic                  overrun_out
);
  localparam int                CNT_W    = $clog2(DATA_WIDTH);
  localparam int                WARM_W   = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [WARM_W-1:0] WARM_END = WARM_W'(SYNC_STAGES);

  typedef enum logic {IDLE, RECV} state_t;

  logic [SYNC_STAGES-1:0] sck_sync, sel_sync, mosi_sync;
  logic                   sck_d, sel_d;
  logic [WARM_W-1:0]      warm_cnt;
  logic                   armed;
  logic                   sck_s, sel_s, mosi_s;
  logic                   sck_rise, sel_fall, sel_rise;

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign sel_s  = sel_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_d;
  assign sel_fall = ~sel_s & sel_d;
  assign sel_rise = sel_s & ~sel_d;

  // The chains restart from their idle values, so a CS that is already low after reset
  // looks like a fresh fall; arming only after CS is truly seen high keeps us out of that frame.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sck_sync  <= '1;
      sel_sync  <= '1;
      mosi_sync <= '0;
      sck_d     <= 1'b1;
      sel_d     <= 1'b1;
      warm_cnt  <= '0;
      armed     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge value, so the chains shift one stage per clock.
      sck_sync  <= (sck_sync << 1)  | SYNC_STAGES'(spi_clk_in);
      sel_sync  <= (sel_sync << 1)  | SYNC_STAGES'(spi_sel_in);
      mosi_sync <= (mosi_sync << 1) | SYNC_STAGES'(spi_data_in);
      sck_d     <= sck_s;
      sel_d     <= sel_s;
      if (warm_cnt != WARM_END) warm_cnt <= warm_cnt + 1'b1;
      else if (sel_s)           armed    <= 1'b1;
    end
  end

  state_t                state;
  logic [CNT_W-1:0]      bit_cnt, cnt_next;
  logic [DATA_WIDTH-2:0] shift_q;    // the MSB leaves straight through shift_next
  logic [DATA_WIDTH-1:0] shift_next;
  logic                  cnt_last, word_done;

  assign shift_next = {shift_q, mosi_s};
  assign cnt_last   = (bit_cnt == LAST_BIT);
  assign cnt_next   = !sck_rise ? bit_cnt : (cnt_last ? '0 : bit_cnt + 1'b1);
  assign word_done  = (state == RECV) & sck_rise & cnt_last;
  assign busy_out   = (state == RECV);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      shift_q       <= '0;
      frame_err_out <= 1'b0;
    end else begin
      frame_err_out <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_fall && armed) begin
            state   <= RECV;
            bit_cnt <= '0;
            shift_q <= '0;
          end
        end
        RECV: begin
          if (sck_rise) begin
            shift_q <= shift_next[DATA_WIDTH-2:0];
            bit_cnt <= cnt_next;
          end
          // A rise in the same cycle is counted first, so a just-finished word is not an error.
          if (sel_rise) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            shift_q       <= '0;
            frame_err_out <= (cnt_next != '0);
          end
        end
      endcase
    end
  end

`ifdef SPI_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] push_data;
  logic                  push_q;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count;
  logic                  full, pop, do_push;

  assign full      = (count == (AW + 1)'(FIFO_DEPTH));
  assign valid_out = (count != '0);
  assign pop       = valid_out & ready_in;
  assign do_push   = push_q & (~full | pop);
  assign data_out  = valid_out ? mem[rd_ptr] : '0;

  // NOTE: storage is left unreset; it is unread until written and data_out is gated while empty.
  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      push_q      <= 1'b0;
      push_data   <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overrun_out <= 1'b0;
    end else begin
      push_q      <= word_done;
      if (word_done) push_data <= shift_next;
      overrun_out <= push_q & full & ~pop;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
`else
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      data_out    <= '0;
      valid_out   <= 1'b0;
      overrun_out <= 1'b0;
    end else begin
      overrun_out <= 1'b0;
      if (word_done) begin
        if (!valid_out || ready_in) begin
          data_out  <= shift_next;
          valid_out <= 1'b1;
        end else begin
          overrun_out <= 1'b1;
        end
      end else if (ready_in) begin
        valid_out <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_spi_rx.sv
// tb_spi_rx: randomized SPI frames against a word-list reference model; checks data, errors, overrun, reset.
module tb_spi_rx;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          spi_clk_in = 1'b1;
  logic          spi_sel_in = 1'b1;
  logic          spi_data_in = 1'b0;
  logic          ready_in = 1'b1;
  logic [DW-1:0] data_out;
  logic          valid_out, busy_out, frame_err_out, overrun_out;

  int compared   = 0;
  int mismatched = 0;
  int busy_low   = 0;

  spi_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(2), .FIFO_DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .spi_clk_in(spi_clk_in), .spi_sel_in(spi_sel_in), .spi_data_in(spi_data_in),
    .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in),
    .busy_out(busy_out), .frame_err_out(frame_err_out), .overrun_out(overrun_out)
  );

  always #5 clk_in = ~clk_in;

  // Monitor: log accepted words and count pulses; only ever appended to, tests use snapshots.
  logic [DW-1:0] rx_log [$];
  int            err_cnt = 0, ovr_cnt = 0, stab_viol = 0;
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (valid_out && ready_in) rx_log.push_back(data_out);
      if (frame_err_out) err_cnt++;
      if (overrun_out)   ovr_cnt++;
      if (prev_hold && (!valid_out || data_out !== prev_data)) stab_viol++;
    end
    prev_hold = valid_out && !ready_in;
    prev_data = data_out;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation still running after 2 ms, required to finish");
    $fatal(1, "timeout");
  end

  task automatic half_bit();
    #(30 + $urandom_range(0, 15));
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      spi_clk_in  = 1'b0;
      spi_data_in = bits[i];
      half_bit();
      spi_clk_in  = 1'b1;
      if (!busy_out) busy_low++;
      half_bit();
    end
  endtask

  task automatic cs_low();
    spi_sel_in = 1'b0;
    #60;
  endtask

  task automatic cs_high();
    #40;
    spi_sel_in = 1'b1;
    #60;
  endtask

  task automatic settle();
    repeat (12) @(posedge clk_in);
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk_in);
    #1 ready_in = r;
  endtask

  // Compare the words logged since 'base' against an expected list.
  task automatic expect_words(input string name, input int base, input logic [DW-1:0] exp_q[$]);
    logic [DW-1:0] got;
    compared++;
    if (rx_log.size() - base != exp_q.size()) begin
      mismatched++;
      $display("FAIL %s_count: got %0d words, expected %0d", name, rx_log.size() - base, exp_q.size());
    end
    foreach (exp_q[i]) begin
      got = (base + i < rx_log.size()) ? rx_log[base + i] : 'x;
      compared++;
      if (got !== exp_q[i]) begin
        mismatched++;
        $display("FAIL %s_word%0d: got %h, expected %h", name, i, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_in);
    #1;
    compared += 5;
    if (data_out !== '0)       begin mismatched++; $display("FAIL reset_data: got %h, expected 00", data_out); end
    if (valid_out !== 1'b0)    begin mismatched++; $display("FAIL reset_valid: got %b, expected 0", valid_out); end
    if (busy_out !== 1'b0)     begin mismatched++; $display("FAIL reset_busy: got %b, expected 0", busy_out); end
    if (frame_err_out !== 1'b0) begin mismatched++; $display("FAIL reset_ferr: got %b, expected 0", frame_err_out); end
    if (overrun_out !== 1'b0)  begin mismatched++; $display("FAIL reset_ovr: got %b, expected 0", overrun_out); end
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (10) @(posedge clk_in);
  endtask

  task automatic test_single();
    logic [DW-1:0] exp_q[$];
    int base = rx_log.size(), e0 = err_cnt, o0 = ovr_cnt;
    exp_q = '{8'hA5, 8'($urandom)};
    foreach (exp_q[i]) begin
      cs_low();
      send_bits(32'(exp_q[i]), DW);
      cs_high();
      settle();
    end
    expect_words("single", base, exp_q);
    compared += 2;
    if (err_cnt != e0) begin mismatched++; $display("FAIL single_ferr: got %0d pulses, expected 0", err_cnt - e0); end
    if (ovr_cnt != o0) begin mismatched++; $display("FAIL single_ovr: got %0d pulses, expected 0", ovr_cnt - o0); end
  endtask

  task automatic test_multi_word();
    logic [DW-1:0] exp_q[$];
    int base = rx_log.size(), b0 = busy_low;
    exp_q = '{8'h3C, 8'hC3, 8'($urandom)};
    cs_low();
    foreach (exp_q[i]) send_bits(32'(exp_q[i]), DW);
    cs_high();
    settle();
    expect_words("multi", base, exp_q);
    compared += 2;
    if (busy_low != b0) begin mismatched++; $display("FAIL multi_busy_held: busy low on %0d bits, expected 0", busy_low - b0); end
    if (busy_out !== 1'b0) begin mismatched++; $display("FAIL multi_busy_after: got %b, expected 0", busy_out); end
  endtask

  task automatic test_frame_err();
    logic [DW-1:0] exp_q[$];
    int base, e0, nbits;
    for (int k = 0; k < 3; k++) begin
      base  = rx_log.size();
      e0    = err_cnt;
      nbits = (k == 0) ? 5 : int'($urandom_range(1, DW - 1));
      cs_low();
      if (k == 2) begin
        exp_q = '{8'($urandom)};
        send_bits(32'(exp_q[0]), DW);
      end else begin
        exp_q = {};
      end
      send_bits($urandom, nbits);
      cs_high();
      settle();
      compared++;
      if (err_cnt - e0 != 1) begin
        mismatched++;
        $display("FAIL ferr_pulse_%0d: got %0d pulses after %0d bits, expected 1", k, err_cnt - e0, nbits);
      end
      expect_words("ferr_partial", base, exp_q);
    end
    base  = rx_log.size();
    e0    = err_cnt;
    exp_q = '{8'h81};
    cs_low();
    send_bits(32'h81, DW);
    cs_high();
    settle();
    expect_words("ferr_recover", base, exp_q);
    compared++;
    if (err_cnt != e0) begin mismatched++; $display("FAIL ferr_recover_err: got %0d pulses, expected 0", err_cnt - e0); end
  endtask

  task automatic test_overrun();
    logic [DW-1:0] exp_q[$];
    int base = rx_log.size(), o0 = ovr_cnt, s0 = stab_viol;
    set_ready(1'b0);
    cs_low();
    send_bits(32'h11, DW);
    send_bits(32'h22, DW);
    cs_high();
    settle();
    #1;
    compared += 4;
    if (valid_out !== 1'b1) begin mismatched++; $display("FAIL ovr_valid_held: got %b, expected 1", valid_out); end
    if (data_out !== 8'h11) begin mismatched++; $display("FAIL ovr_data_held: got %h, expected 11", data_out); end
    if (stab_viol != s0)    begin mismatched++; $display("FAIL ovr_stable: %0d changes while stalled, expected 0", stab_viol - s0); end
`ifdef SPI_RX_FIFO_EN
    if (ovr_cnt != o0) begin mismatched++; $display("FAIL ovr_pulses: got %0d, expected 0", ovr_cnt - o0); end
    exp_q = '{8'h11, 8'h22};
`else
    if (ovr_cnt - o0 != 1) begin mismatched++; $display("FAIL ovr_pulses: got %0d, expected 1", ovr_cnt - o0); end
    exp_q = '{8'h11};
`endif
    set_ready(1'b1);
    settle();
    expect_words("ovr_drain", base, exp_q);
    compared++;
    if (valid_out !== 1'b0) begin mismatched++; $display("FAIL ovr_drained_valid: got %b, expected 0", valid_out); end
  endtask

`ifdef SPI_RX_FIFO_EN
  task automatic test_fifo_full();
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] w;
    int base = rx_log.size(), o0 = ovr_cnt;
    exp_q = {};
    set_ready(1'b0);
    cs_low();
    for (int i = 0; i < DEPTH; i++) begin
      w = 8'($urandom);
      exp_q.push_back(w);
      send_bits(32'(w), DW);
    end
    settle();
    compared++;
    if (ovr_cnt != o0) begin mismatched++; $display("FAIL full_early_ovr: got %0d, expected 0", ovr_cnt - o0); end
    send_bits($urandom, DW);
    cs_high();
    settle();
    compared++;
    if (ovr_cnt - o0 != 1) begin mismatched++; $display("FAIL full_last_ovr: got %0d, expected 1", ovr_cnt - o0); end
    set_ready(1'b1);
    settle();
    expect_words("full_drain", base, exp_q);
  endtask
`endif

  task automatic test_reset_mid_frame();
    logic [DW-1:0] exp_q[$];
    int base = rx_log.size(), e0 = err_cnt;
    cs_low();
    send_bits(32'h7, 3);           // first three bits of 0xF0
    #3 rst_in = 1'b1;
    #1;
    compared += 4;
    if (busy_out !== 1'b0)  begin mismatched++; $display("FAIL rstmid_busy: got %b, expected 0", busy_out); end
    if (valid_out !== 1'b0) begin mismatched++; $display("FAIL rstmid_valid: got %b, expected 0", valid_out); end
    if (data_out !== '0)    begin mismatched++; $display("FAIL rstmid_data: got %h, expected 00", data_out); end
    if (frame_err_out !== 1'b0) begin mismatched++; $display("FAIL rstmid_ferr: got %b, expected 0", frame_err_out); end
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    send_bits(32'h10, 5);          // remaining bits of 0xF0
    cs_high();
    settle();
    exp_q = {};
    expect_words("rstmid_tail", base, exp_q);
    compared++;
    if (err_cnt != e0) begin mismatched++; $display("FAIL rstmid_tail_err: got %0d pulses, expected 0", err_cnt - e0); end
    base  = rx_log.size();
    exp_q = '{8'h5A};
    cs_low();
    send_bits(32'h5A, DW);
    cs_high();
    settle();
    expect_words("rstmid_next", base, exp_q);
  endtask

  task automatic test_random_frames();
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] w;
    int base = rx_log.size(), e0 = err_cnt, o0 = ovr_cnt;
    exp_q = {};
    for (int f = 0; f < 20; f++) begin
      cs_low();
      for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
        w = 8'($urandom);
        exp_q.push_back(w);
        send_bits(32'(w), DW);
      end
      cs_high();
      settle();
    end
    expect_words("random", base, exp_q);
    compared += 2;
    if (err_cnt != e0) begin mismatched++; $display("FAIL random_ferr: got %0d pulses, expected 0", err_cnt - e0); end
    if (ovr_cnt != o0) begin mismatched++; $display("FAIL random_ovr: got %0d pulses, expected 0", ovr_cnt - o0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_word();
    test_frame_err();
    test_overrun();
`ifdef SPI_RX_FIFO_EN
    test_fifo_full();
`endif
    test_reset_mid_frame();
    test_random_frames();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
